// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg: opcodes, ALU codes, states and strobe decode for the control unit. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                          OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                          OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                          OP_SHR  = 5'd9,  OP_SHL  = 5'd10, OP_ADDI = 5'd12,
                          OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_MUL  = 5'd15,
                          OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18,
                          OP_BR   = 5'd19, OP_JR   = 5'd20, OP_IN   = 5'd22,
                          OP_OUT  = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25,
                          OP_NOP  = 5'd26, OP_HALT = 5'd27;

   localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_NOT = 4'd2,  ALU_NEG = 4'd3,
                          ALU_ADD = 4'd4, ALU_SUB = 4'd5, ALU_MUL = 4'd6,  ALU_DIV = 4'd7,
                          ALU_SHR = 4'd8, ALU_SHL = 4'd9, ALU_ROR = 4'd10, ALU_ROL = 4'd11;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
      S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
   } state_e;

   typedef struct packed {
      logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, IRin, Yin;
      logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
      logic Gra, Grb, Grc, Rin, Rout, BAout, Csignout, CONin;
      logic InPortout, Out_Portin, Read, Write;
   } strobes_t;

   function automatic logic is_rtype(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
         OP_ROR, OP_ROL, OP_NEG, OP_NOT: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic logic is_itype(input logic [4:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_mem(input logic [4:0] op);
      return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   endfunction

   function automatic logic is_defined(input logic [4:0] op);
      return !((op == 5'd11) || (op == 5'd21) || (op > OP_HALT));
   endfunction

   function automatic logic [3:0] alu_code(input logic [4:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR,  OP_ORI:  return ALU_OR;
         OP_SHR:          return ALU_SHR;
         OP_SHL:          return ALU_SHL;
         OP_ROR:          return ALU_ROR;
         OP_ROL:          return ALU_ROL;
         OP_NEG:          return ALU_NEG;
         OP_NOT:          return ALU_NOT;
         OP_MUL:          return ALU_MUL;
         OP_DIV:          return ALU_DIV;
         default:         return ALU_ADD;
      endcase
   endfunction

   // Strobes of a state; the br T6 PC load is gated by CONFF outside this table.
   function automatic strobes_t state_strobes(input state_e s, input logic [4:0] op);
      strobes_t st;
      st = '0;
      case (s)
         S_T0: begin st.PCout = 1'b1; st.MARin = 1'b1; st.IncPC = 1'b1; st.Zlowin = 1'b1; end
         S_T1: begin
            st.Zlowout = 1'b1; st.PCin = 1'b1; st.Read = 1'b1; st.MD_read = 1'b1; st.MDRin = 1'b1;
         end
         S_T2: begin st.MDRout = 1'b1; st.IRin = 1'b1; end
         S_T3: begin
            if (is_rtype(op) || is_itype(op)) begin st.Grb = 1'b1; st.Rout = 1'b1; st.Yin = 1'b1; end
            else if (is_muldiv(op))           begin st.Gra = 1'b1; st.Rout = 1'b1; st.Yin = 1'b1; end
            else if (is_mem(op))              begin st.Grb = 1'b1; st.BAout = 1'b1; st.Yin = 1'b1; end
            else begin
               case (op)
                  OP_BR:   begin st.Gra = 1'b1; st.Rout = 1'b1; st.CONin = 1'b1; end
                  OP_JR:   begin st.Gra = 1'b1; st.Rout = 1'b1; st.PCin = 1'b1; end
                  OP_IN:   begin st.InPortout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1; end
                  OP_OUT:  begin st.Gra = 1'b1; st.Rout = 1'b1; st.Out_Portin = 1'b1; end
                  OP_MFHI: begin st.HIout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1; end
                  OP_MFLO: begin st.LOout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1; end
                  default: ;
               endcase
            end
         end
         S_T4: begin
            if (is_rtype(op))       begin st.Grc = 1'b1; st.Rout = 1'b1; st.Zlowin = 1'b1; end
            else if (is_itype(op) || is_mem(op)) begin st.Csignout = 1'b1; st.Zlowin = 1'b1; end
            else if (is_muldiv(op)) begin
               st.Grb = 1'b1; st.Rout = 1'b1; st.Zlowin = 1'b1; st.Zhighin = 1'b1;
            end
            else if (op == OP_BR)   begin st.PCout = 1'b1; st.Yin = 1'b1; end
         end
         S_T5: begin
            if (is_rtype(op) || is_itype(op) || op == OP_LDI) begin
               st.Zlowout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1;
            end
            else if (is_muldiv(op)) begin st.Zlowout = 1'b1; st.LOin = 1'b1; end
            else if (is_mem(op))    begin st.Zlowout = 1'b1; st.MARin = 1'b1; end
            else if (op == OP_BR)   begin st.Csignout = 1'b1; st.Zlowin = 1'b1; end
         end
         S_T6: begin
            if (is_muldiv(op))     begin st.Zhighout = 1'b1; st.HIin = 1'b1; end
            else if (op == OP_LD)  begin st.Read = 1'b1; st.MD_read = 1'b1; st.MDRin = 1'b1; end
            else if (op == OP_ST)  begin st.Gra = 1'b1; st.Rout = 1'b1; st.MDRin = 1'b1; end
         end
         S_T7: begin
            if (op == OP_LD)       begin st.MDRout = 1'b1; st.Gra = 1'b1; st.Rin = 1'b1; end
            else if (op == OP_ST)  st.Write = 1'b1;
         end
         default: ;
      endcase
      return st;
   endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter: holds a memory T-state for MEM_WAIT cycles; done when count is 0. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_wait_counter #(
   parameter int MEM_WAIT = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   output logic done_o
);

   logic [2:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             cnt_q <= 3'd0;
      else if (load_i)         cnt_q <= 3'(MEM_WAIT - 1);
      else if (cnt_q != 3'd0)  cnt_q <= cnt_q - 3'd1;
   end

   assign done_o = (cnt_q == 3'd0);

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer: hardwired fetch/decode/execute control unit for the bus datapath. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 1,
   parameter int OPW      = 5
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        CONFF,
   output logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, IRin, Yin,
   output logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
   output logic Gra, Grb, Grc, Rin, Rout, BAout, Csignout, CONin,
   output logic InPortout, Out_Portin, Read, Write,
   output logic [3:0]  alu_op,
   output logic        halted,
   output logic        illegal
);

   state_e     state_q, state_d;
   logic [4:0] op_q;
   strobes_t   strb_q, w_strb;
   logic [3:0] alu_op_q;
   logic       halted_q, illegal_q, brt6_q;
   logic       w_last, w_load, w_done, w_br_take;
   logic [4:0] w_ir_op, w_op_dec;
   logic       w_unused_ir;

   assign w_ir_op     = 5'(ir[31 -: OPW]);
   assign w_unused_ir = ^ir[31-OPW:0];
   // The opcode is taken straight from ir on the edge into T3 and held afterwards.
   assign w_op_dec    = (state_q == S_T2) ? w_ir_op : op_q;

   assign w_load = (state_q == S_T0) || (state_q == S_T5 && op_q == OP_LD) ||
                   (state_q == S_T6 && op_q == OP_ST);

   mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
      .clk_i  (clock),
      .rst_ni (clear_n),
      .load_i (w_load),
      .done_o (w_done)
   );

   always_comb begin
      state_d = state_q;
      w_last  = 1'b0;
      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (w_done) state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            if (op_q == OP_HALT) state_d = S_HALT;
            else if (is_rtype(op_q) || is_itype(op_q) || is_muldiv(op_q) ||
                     is_mem(op_q) || op_q == OP_BR) state_d = S_T4;
            else w_last = 1'b1;
         end
         S_T4:   state_d = S_T5;
         S_T5: begin
            if (is_rtype(op_q) || is_itype(op_q) || op_q == OP_LDI) w_last = 1'b1;
            else state_d = S_T6;
         end
         S_T6: begin
            if (op_q == OP_LD)      begin if (w_done) state_d = S_T7; end
            else if (op_q == OP_ST) state_d = S_T7;
            else                    w_last = 1'b1;
         end
         S_T7: begin
            if (op_q == OP_ST) begin if (w_done) w_last = 1'b1; end
            else               w_last = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (w_last) state_d = run ? S_T0 : S_IDLE;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= S_IDLE;
         op_q      <= OP_NOP;
         strb_q    <= '0;
         alu_op_q  <= ALU_ADD;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         brt6_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (state_q == S_T2) op_q <= w_ir_op;
         strb_q    <= state_strobes(state_d, w_op_dec);
         alu_op_q  <= (state_d == S_T4) ? alu_code(w_op_dec) : ALU_ADD;
         halted_q  <= (state_d == S_HALT);
         illegal_q <= (state_d == S_T3) && !is_defined(w_op_dec);
         brt6_q    <= (state_d == S_T6) && (w_op_dec == OP_BR);
      end
   end

   // The branch decision uses CONFF as seen during T6 itself.
   assign w_br_take = brt6_q & CONFF;

   always_comb begin
      w_strb         = strb_q;
      w_strb.Zlowout = strb_q.Zlowout | w_br_take;
      w_strb.PCin    = strb_q.PCin    | w_br_take;
   end

   assign {PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, IRin, Yin,
           Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
           Gra, Grb, Grc, Rin, Rout, BAout, Csignout, CONin,
           InPortout, Out_Portin, Read, Write} = w_strb;

   assign alu_op  = alu_op_q;
   assign halted  = halted_q;
   assign illegal = illegal_q;

   a_one_bus_driver: assert property (@(posedge clock) disable iff (!clear_n)
      $onehot0({PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Rout, BAout, Csignout, InPortout}));

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer: directed self-checking bench for control_sequencer (MEM_WAIT=3). Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer
   import cpu_ctrl_pkg::*;
;

   logic        clock = 1'b0, clear_n = 1'b0, run = 1'b0, CONFF = 1'b0;
   logic [31:0] ir = 32'h0;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, IRin, Yin;
   logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Csignout, CONin;
   logic InPortout, Out_Portin, Read, Write, halted, illegal;
   logic [3:0] alu_op;
   int total = 0, bad = 0;

   control_sequencer #(.MEM_WAIT(3), .OPW(5)) dut (
      .clock(clock), .clear_n(clear_n), .run(run), .ir(ir), .CONFF(CONFF),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .MD_read(MD_read), .IRin(IRin), .Yin(Yin),
      .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Csignout(Csignout), .CONin(CONin), .InPortout(InPortout), .Out_Portin(Out_Portin),
      .Read(Read), .Write(Write), .alu_op(alu_op), .halted(halted), .illegal(illegal)
   );

   always #5 clock = ~clock;

   logic [28:0] sv;
   assign sv = {Write, Read, Out_Portin, InPortout, CONin, Csignout, BAout, Rout, Rin, Grc, Grb, Gra,
                LOout, HIout, LOin, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Yin, IRin, MD_read,
                MDRout, MDRin, MARin, IncPC, PCin, PCout};

   localparam logic [28:0] B_PCout = 29'd1 << 0,  B_PCin = 29'd1 << 1,   B_IncPC = 29'd1 << 2,
      B_MARin = 29'd1 << 3,  B_MDRin = 29'd1 << 4,  B_MDRout = 29'd1 << 5, B_MD_read = 29'd1 << 6,
      B_IRin = 29'd1 << 7,   B_Yin = 29'd1 << 8,    B_Zlowin = 29'd1 << 9, B_Zhighin = 29'd1 << 10,
      B_Zlowout = 29'd1 << 11, B_Zhighout = 29'd1 << 12, B_HIin = 29'd1 << 13, B_LOin = 29'd1 << 14,
      B_HIout = 29'd1 << 15, B_LOout = 29'd1 << 16, B_Gra = 29'd1 << 17,  B_Grb = 29'd1 << 18,
      B_Grc = 29'd1 << 19,   B_Rin = 29'd1 << 20,   B_Rout = 29'd1 << 21, B_BAout = 29'd1 << 22,
      B_Csignout = 29'd1 << 23, B_CONin = 29'd1 << 24, B_InPortout = 29'd1 << 25,
      B_Out_Portin = 29'd1 << 26, B_Read = 29'd1 << 27, B_Write = 29'd1 << 28;

   localparam logic [28:0] M_T0 = B_PCout | B_MARin | B_IncPC | B_Zlowin;
   localparam logic [28:0] M_T1 = B_Zlowout | B_PCin | B_Read | B_MD_read | B_MDRin;
   localparam logic [28:0] M_T2 = B_MDRout | B_IRin;
   localparam logic [28:0] M_NONE = 29'd0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op);
      return {op, 27'h0312345};
   endfunction

   // Independent watch on the shared bus: never more than one *out driver.
   always @(negedge clock) begin
      if (clear_n) begin
         total++;
         if ($countones({PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Rout, BAout,
                         Csignout, InPortout}) > 1) begin
            bad++;
            $display("FAIL bus_drivers at %0t: strobes=%h required at most one *out", $time, sv);
         end
      end
   end

   task automatic test_reset();
      clear_n = 1'b0; run = 1'b0;
      repeat (3) tick();
      total++;
      if ({sv, alu_op, halted, illegal} !== {29'd0, 4'b0100, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset: strobes=%h alu=%h halted=%b illegal=%b required 0/4/0/0",
                  sv, alu_op, halted, illegal);
      end
      clear_n = 1'b1;
      tick();
      total++;
      if (sv !== M_NONE) begin bad++; $display("FAIL reset_idle: strobes=%h required 0", sv); end
   endtask

   task automatic test_add_sub();
      logic [28:0] e [0:16];
      logic [28:0] r3, r4, r5;
      r3 = B_Grb | B_Rout | B_Yin; r4 = B_Grc | B_Rout | B_Zlowin; r5 = B_Zlowout | B_Gra | B_Rin;
      e = '{M_T0, M_T1, M_T1, M_T1, M_T2, r3, r4, r5, M_T0, M_T1, M_T1, M_T1, M_T2, r3, r4, r5, M_NONE};
      ir = mk(OP_ADD); run = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         total++;
         if (sv !== e[i]) begin bad++; $display("FAIL add_sub step %0d: strobes=%h required %h", i, sv, e[i]); end
         if (i == 6 || i == 14) begin
            total++;
            if (alu_op !== ((i == 6) ? ALU_ADD : ALU_SUB)) begin
               bad++; $display("FAIL add_sub alu step %0d: alu_op=%h", i, alu_op);
            end
         end
         if (i == 8) begin run = 1'b0; ir = mk(OP_SUB); end
      end
   endtask

   task automatic test_ld();
      logic [28:0] e [0:12];
      logic [28:0] l6;
      int rd;
      rd = 0;
      l6 = B_Read | B_MD_read | B_MDRin;
      e = '{M_T0, M_T1, M_T1, M_T1, M_T2, B_Grb | B_BAout | B_Yin, B_Csignout | B_Zlowin,
            B_Zlowout | B_MARin, l6, l6, l6, B_MDRout | B_Gra | B_Rin, M_NONE};
      ir = mk(OP_LD); run = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i == 0) run = 1'b0;
         rd += int'(Read);
         total++;
         if (sv !== e[i]) begin bad++; $display("FAIL ld step %0d: strobes=%h required %h", i, sv, e[i]); end
      end
      total++;
      if (rd != 6) begin bad++; $display("FAIL ld_read_cycles: got %0d required 6", rd); end
   endtask

   task automatic test_br();
      logic [28:0] e [0:9];
      int cons;
      for (int c = 0; c < 2; c++) begin
         cons = 0;
         e = '{M_T0, M_T1, M_T1, M_T1, M_T2, B_Gra | B_Rout | B_CONin, B_PCout | B_Yin,
               B_Csignout | B_Zlowin, (c == 1) ? (B_Zlowout | B_PCin) : M_NONE, M_NONE};
         CONFF = (c == 1); ir = mk(OP_BR); run = 1'b1;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) run = 1'b0;
            cons += int'(CONin);
            total++;
            if (sv !== e[i]) begin
               bad++; $display("FAIL br conff=%0d step %0d: strobes=%h required %h", c, i, sv, e[i]);
            end
         end
         total++;
         if (cons != 1) begin bad++; $display("FAIL br_conin conff=%0d: pulses=%0d required 1", c, cons); end
      end
      CONFF = 1'b0;
   endtask

   task automatic test_single_step();
      logic [4:0]  ops [0:4];
      logic [28:0] m   [0:4];
      ops = '{OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
      m   = '{B_Gra | B_Rout | B_PCin, B_InPortout | B_Gra | B_Rin, B_Gra | B_Rout | B_Out_Portin,
              B_HIout | B_Gra | B_Rin, B_LOout | B_Gra | B_Rin};
      for (int k = 0; k < 5; k++) begin
         ir = mk(ops[k]); run = 1'b1;
         tick();
         run = 1'b0;
         repeat (4) tick();
         tick();
         total++;
         if (sv !== m[k]) begin bad++; $display("FAIL single op=%0d T3: strobes=%h required %h", ops[k], sv, m[k]); end
         tick();
         total++;
         if (sv !== M_NONE) begin bad++; $display("FAIL single op=%0d idle: strobes=%h required 0", ops[k], sv); end
      end
   endtask

   task automatic test_mul();
      logic [28:0] e [0:9];
      e = '{M_T0, M_T1, M_T1, M_T1, M_T2, B_Gra | B_Rout | B_Yin,
            B_Grb | B_Rout | B_Zlowin | B_Zhighin, B_Zlowout | B_LOin, B_Zhighout | B_HIin, M_NONE};
      ir = mk(OP_MUL); run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) run = 1'b0;
         total++;
         if (sv !== e[i]) begin bad++; $display("FAIL mul step %0d: strobes=%h required %h", i, sv, e[i]); end
         if (i == 6) begin
            total++;
            if (alu_op !== ALU_MUL) begin bad++; $display("FAIL mul_alu: alu_op=%h required %h", alu_op, ALU_MUL); end
         end
      end
   endtask

   task automatic test_st_halt();
      logic [28:0] e [0:17];
      int wr;
      wr = 0;
      e = '{M_T0, M_T1, M_T1, M_T1, M_T2, B_Grb | B_BAout | B_Yin, B_Csignout | B_Zlowin,
            B_Zlowout | B_MARin, B_Gra | B_Rout | B_MDRin, B_Write, B_Write, B_Write,
            M_T0, M_T1, M_T1, M_T1, M_T2, M_NONE};
      ir = mk(OP_ST); run = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         if (i == 5) ir = mk(OP_HALT);
         wr += int'(Write);
         total++;
         if (sv !== e[i]) begin bad++; $display("FAIL st_halt step %0d: strobes=%h required %h", i, sv, e[i]); end
      end
      total++;
      if (wr != 3) begin bad++; $display("FAIL st_write_cycles: got %0d required 3", wr); end
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if ({halted, sv} !== {1'b1, M_NONE}) begin
            bad++; $display("FAIL halt_hold cycle %0d: halted=%b strobes=%h required 1/0", i, halted, sv);
         end
      end
   endtask

   task automatic test_reset_mid_and_illegal();
      logic [28:0] e [0:12];
      clear_n = 1'b0;
      tick();
      clear_n = 1'b1;
      ir = mk(OP_LD); run = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 0) run = 1'b0;
      end
      total++;
      if (sv !== (B_Read | B_MD_read | B_MDRin)) begin bad++; $display("FAIL ld_T6_before_reset: strobes=%h", sv); end
      #2 clear_n = 1'b0;
      #1;
      total++;
      if ({sv, alu_op, halted} !== {M_NONE, 4'b0100, 1'b0}) begin
         bad++; $display("FAIL async_reset: strobes=%h alu=%h halted=%b required 0/4/0", sv, alu_op, halted);
      end
      tick();
      clear_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (sv !== M_NONE) begin bad++; $display("FAIL idle_after_reset cycle %0d: strobes=%h required 0", i, sv); end
      end
      e = '{M_T0, M_T1, M_T1, M_T1, M_T2, M_NONE, M_T0, M_T1, M_T1, M_T1, M_T2, M_NONE, M_NONE};
      ir = {5'd31, 27'h0}; run = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i == 5) ir = mk(OP_NOP);
         if (i == 6) run = 1'b0;
         total++;
         if ({sv, illegal} !== {e[i], (i == 5)}) begin
            bad++; $display("FAIL illegal step %0d: strobes=%h illegal=%b required %h/%b", i, sv, illegal, e[i], (i == 5));
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_ld();
      test_br();
      test_single_step();
      test_mul();
      test_st_halt();
      test_reset_mid_and_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
